// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/stall controller slice: the two-state
//   FSM encoding, the hard-wired zero register number, and the default
//   HI/LO busy latency applied after a mult/div leaves EX.
//   No ports (package only).
package hazard_pkg;

    // Two-state sequencer: normal issue, or waiting for HI/LO to settle
    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MUL_WAIT = 1'b1
    } hz_state_t;

    // $zero is never a real producer, so it never creates a RAW hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles HI/LO stay unusable after a mult/div leaves EX
    localparam int DEFAULT_MUL_LAT = 4;

endpackage

// File: rtl/hazard_reg_compare.sv
// hazard_reg_compare
//   Combinational source/destination comparator for the ID stage. Flags a
//   RAW hazard when a register read by the ID instruction is about to be
//   written by the instruction in EX or MEM. WB is not compared because
//   the register file writes in the first half of the cycle.
// Ports
//   id_rs, id_rt            in  5  source fields of the ID instruction
//   id_uses_rs, id_uses_rt  in  1  qualify whether each source is read
//   ex_reg_write, ex_dst_reg    in   EX producer
//   mem_reg_write, mem_dst_reg  in   MEM producer
//   raw_haz                 out 1  ID must wait for a producer
module hazard_reg_compare
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_dst_reg,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dst_reg,
    output logic       raw_haz
);

    logic rs_match;
    logic rt_match;

    // A source matches when a live producer in EX or MEM targets it;
    // register 0 is excluded because writes to it are discarded.
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        if (id_rs != REG_ZERO) begin
            rs_match = (ex_reg_write  && (ex_dst_reg  == id_rs)) ||
                       (mem_reg_write && (mem_dst_reg == id_rs));
        end
        if (id_rt != REG_ZERO) begin
            rt_match = (ex_reg_write  && (ex_dst_reg  == id_rt)) ||
                       (mem_reg_write && (mem_dst_reg == id_rt));
        end
    end

    assign raw_haz = (id_uses_rs && rs_match) || (id_uses_rt && rt_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Sequences a 5-stage pipeline without forwarding. Produces the PC and
//   IF_ID load enables plus per-stage flushes: bubbles for RAW hazards and
//   for HI/LO reads behind a multi-cycle mult/div, and wrong-path flushes
//   when a branch/jump resolves in MEM. Outputs are combinational from the
//   FSM state and the current inputs.
// Parameters
//   MUL_LAT  cycles HI/LO are unusable after a mult/div leaves EX (1..15)
//   CNT_W    statistics counter width (only with HAZARD_STATS_EN)
// Ports
//   Clk, Rst                          clock, synchronous active-high reset
//   ID_Rs/ID_Rt/ID_UsesRs/ID_UsesRt   ID register sources
//   ID_UsesHiLo                       ID reads HI or LO
//   EX_RegWrite/EX_DstReg/EX_HiLoWrite  EX producer, mult/div issue
//   MEM_RegWrite/MEM_DstReg           MEM producer
//   MEM_Redirect                      taken branch or jump in MEM
//   PC_Ld, IF_ID_Ld                   load enables
//   IF_ID_Flush/ID_EX_Flush/EX_MEM_Flush  clear next edge
//   Stall                             pipeline frozen this cycle
// Configuration
//   HAZARD_STATS_EN: adds StallCycles, FlushEvents, MulWaitCycles
//   saturating counters (CNT_W bits each), cleared by Rst.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
)(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_UsesHiLo,
    input  logic       EX_RegWrite,
    input  logic [4:0] EX_DstReg,
    input  logic [1:0] EX_HiLoWrite,
    input  logic       MEM_RegWrite,
    input  logic [4:0] MEM_DstReg,
    input  logic       MEM_Redirect,
    output logic       PC_Ld,
    output logic       IF_ID_Ld,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       Stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents,
    output logic [CNT_W-1:0] MulWaitCycles
`endif
);

    localparam logic [3:0] MUL_LAT_CNT = 4'(MUL_LAT);

    hz_state_t  state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       raw_haz;
    logic       hilo_haz;
    logic       mul_issue;

    hazard_reg_compare u_reg_compare (
        .id_rs         (ID_Rs),
        .id_rt         (ID_Rt),
        .id_uses_rs    (ID_UsesRs),
        .id_uses_rt    (ID_UsesRt),
        .ex_reg_write  (EX_RegWrite),
        .ex_dst_reg    (EX_DstReg),
        .mem_reg_write (MEM_RegWrite),
        .mem_dst_reg   (MEM_DstReg),
        .raw_haz       (raw_haz)
    );

    // A mult/div in EX that is being flushed by a redirect never executes,
    // so only an un-flushed one arms or re-arms the HI/LO wait.
    assign mul_issue = (EX_HiLoWrite != 2'b00) && !MEM_Redirect;

    // HI/LO are stale both while waiting and in the issue cycle itself.
    assign hilo_haz = ID_UsesHiLo &&
                      ((state_q == HZ_MUL_WAIT) || (EX_HiLoWrite != 2'b00));

    // State register; reset also aborts any HI/LO wait in progress.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= HZ_RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next state: the counter holds the remaining busy cycles including the
    // current one, so the FSM leaves MUL_WAIT on the edge where it reads 1.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            HZ_RUN: begin
                mul_cnt_d = 4'd0;
                if (mul_issue) begin
                    state_d   = HZ_MUL_WAIT;
                    mul_cnt_d = MUL_LAT_CNT;
                end
            end
            HZ_MUL_WAIT: begin
                if (mul_issue) begin
                    mul_cnt_d = MUL_LAT_CNT;
                end else if (mul_cnt_q <= 4'd1) begin
                    state_d   = HZ_RUN;
                    mul_cnt_d = 4'd0;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = HZ_RUN;
                mul_cnt_d = 4'd0;
            end
        endcase
    end

    // Priority mux: redirect beats stall beats normal flow. Reset forces the
    // free-running pattern so the datapath behaves like the old 1'b1 ties.
    always_comb begin
        PC_Ld        = 1'b1;
        IF_ID_Ld     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Stall        = 1'b0;
        if (!Rst) begin
            if (MEM_Redirect) begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
                EX_MEM_Flush = 1'b1;
            end else if (raw_haz || hilo_haz) begin
                PC_Ld       = 1'b0;
                IF_ID_Ld    = 1'b0;
                ID_EX_Flush = 1'b1;
                Stall       = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating event counters; holding at all-ones keeps a long run from
    // wrapping back to a misleadingly small value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCycles   <= '0;
            FlushEvents   <= '0;
            MulWaitCycles <= '0;
        end else begin
            if (Stall && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (MEM_Redirect && (FlushEvents != CNT_MAX)) begin
                FlushEvents <= FlushEvents + CNT_W'(1);
            end
            if ((state_q == HZ_MUL_WAIT) && (MulWaitCycles != CNT_MAX)) begin
                MulWaitCycles <= MulWaitCycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule
